// File: rtl/wb_rr_arbiter_pkg.sv
// Shared helpers for the writeback arbiter slice.
// Holds the grant-index width helper and the default sizing of the integer writeback path.
// wb_packet_t stays fixed XLEN elsewhere; the arbiter uses flattened ports because
// package typedefs cannot follow a DATA_WIDTH parameter.
package wb_rr_arbiter_pkg;

  // clog2 with a floor of 1 so a single-unit arbiter still has a 1-bit index port.
  function automatic int wb_unit_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WB_DEF_NUM_UNITS  = 4;
  localparam int WB_DEF_DATA_WIDTH = 32;
  localparam int WB_DEF_ID_W       = 3;
  localparam int WB_UNIT_IDX_W     = wb_unit_idx_w(WB_DEF_NUM_UNITS);

endpackage

// File: rtl/wb_rr_arbiter_rr_grant.sv
// Purpose: one-hot grant selection over a request vector, rotating or fixed priority.
// Latency: combinational grant; priority pointer updates on the clock edge after a grant.
// Backpressure: en=0 blocks every grant and freezes the pointer; requests simply wait.
//
// Ports:
//   clk, rst   core clock, async active-high reset
//   req        request vector, one bit per unit
//   en         grant enable (low while suppressed or in reset)
//   grant      one-hot grant, subset of req
//   grant_idx  binary index of the granted unit (0 when nothing granted)
module rr_grant
  import wb_rr_arbiter_pkg::*;
#(
  parameter  int NUM_UNITS   = 4,
  parameter  int ROUND_ROBIN = 1,
  localparam int IDX_W       = wb_unit_idx_w(NUM_UNITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_UNITS-1:0] req,
  input  logic                 en,
  output logic [NUM_UNITS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  // Index of the most recent winner; the search starts just after it.
  // In fixed-priority mode it never leaves its reset value NUM_UNITS-1, so the
  // search always starts at unit 0 and the lowest valid index wins.
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_UNITS);
      if (en && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(NUM_UNITS - 1);
    end else if ((ROUND_ROBIN != 0) && found) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Purpose: N-input writeback arbiter; picks one id-tagged unit result per cycle.
// Latency: ack is same-cycle combinational; wb_* is registered, valid one cycle after the ack.
// Backpressure: none on the writeback side; wb_suppress withholds all acks so units wait.
//
// Ports:
//   clk, rst     core clock, async active-high reset
//   unit_valid   per-unit result pending
//   unit_id      per-unit id, slice [i*ID_W +: ID_W]
//   unit_data    per-unit result, slice [i*DATA_WIDTH +: DATA_WIDTH]
//   unit_ack     one-hot grant, result of unit i consumed this cycle
//   wb_suppress  global writeback suppress, blocks all grants
//   wb_valid     registered writeback strobe (1-cycle pulse per grant)
//   wb_id        registered id of the granted result
//   wb_data      registered data of the granted result
//   wb_unit      index of the unit that produced wb_*
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter  int NUM_UNITS   = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int ID_W        = 3,
  parameter  int ROUND_ROBIN = 1,
  localparam int IDX_W       = wb_unit_idx_w(NUM_UNITS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_UNITS-1:0]            unit_valid,
  input  logic [NUM_UNITS*ID_W-1:0]       unit_id,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_data,
  output logic [NUM_UNITS-1:0]            unit_ack,
  input  logic                            wb_suppress,
  output logic                            wb_valid,
  output logic [ID_W-1:0]                 wb_id,
  output logic [DATA_WIDTH-1:0]           wb_data,
  output logic [IDX_W-1:0]                wb_unit
);

  logic [NUM_UNITS-1:0]  grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_en;
  logic [ID_W-1:0]       sel_id;
  logic [DATA_WIDTH-1:0] sel_data;

  // Gating with rst keeps acks low during reset, so a unit never retires a
  // result that the cleared output register would then drop.
  assign grant_en = ~wb_suppress & ~rst;

  rr_grant #(
    .NUM_UNITS   (NUM_UNITS),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_grant (
    .clk       (clk),
    .rst       (rst),
    .req       (unit_valid),
    .en        (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign unit_ack = grant;

  // One-hot AND-OR select: the grant is already one-hot, so no priority chain is needed.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      sel_id   = sel_id   | (unit_id[i*ID_W +: ID_W]             & {ID_W{grant[i]}});
      sel_data = sel_data | (unit_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
    end
  end

  // Payload flops only load on a grant so they hold the last writeback when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_id    <= '0;
      wb_data  <= '0;
      wb_unit  <= '0;
    end else begin
      wb_valid <= |grant;
      if (|grant) begin
        wb_id   <= sel_id;
        wb_data <= sel_data;
        wb_unit <= grant_idx;
      end
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(unit_ack));

  a_ack_valid: assert property (@(posedge clk) disable iff (rst)
    ((unit_ack & ~unit_valid) == '0));

  a_no_ack_suppress: assert property (@(posedge clk) disable iff (rst)
    wb_suppress |-> (unit_ack == '0));

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_stable
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (unit_valid[i] && !unit_ack[i]) |=>
        ($stable(unit_id[i*ID_W +: ID_W]) && $stable(unit_data[i*DATA_WIDTH +: DATA_WIDTH])));
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance
  logic [N-1:0]    unit_valid, unit_ack;
  logic [N*IW-1:0] unit_id;
  logic [N*DW-1:0] unit_data;
  logic            wb_suppress, wb_valid;
  logic [IW-1:0]   wb_id;
  logic [DW-1:0]   wb_data;
  logic [1:0]      wb_unit;

  // Fixed-priority instance
  logic [N-1:0]    f_valid, f_ack;
  logic [N*IW-1:0] f_id;
  logic [N*DW-1:0] f_data;
  logic            f_sup, f_wb_valid;
  logic [IW-1:0]   f_wb_id;
  logic [DW-1:0]   f_wb_data;
  logic [1:0]      f_wb_unit;

  // Single-unit instance
  logic [0:0]      s_valid, s_ack;
  logic [IW-1:0]   s_id;
  logic [DW-1:0]   s_data;
  logic            s_sup, s_wb_valid;
  logic [IW-1:0]   s_wb_id;
  logic [DW-1:0]   s_wb_data;
  logic [0:0]      s_wb_unit;

  wb_rr_arbiter #(.NUM_UNITS(N), .DATA_WIDTH(DW), .ID_W(IW), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst(rst), .unit_valid(unit_valid), .unit_id(unit_id), .unit_data(unit_data),
    .unit_ack(unit_ack), .wb_suppress(wb_suppress), .wb_valid(wb_valid), .wb_id(wb_id),
    .wb_data(wb_data), .wb_unit(wb_unit));

  wb_rr_arbiter #(.NUM_UNITS(N), .DATA_WIDTH(DW), .ID_W(IW), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst), .unit_valid(f_valid), .unit_id(f_id), .unit_data(f_data),
    .unit_ack(f_ack), .wb_suppress(f_sup), .wb_valid(f_wb_valid), .wb_id(f_wb_id),
    .wb_data(f_wb_data), .wb_unit(f_wb_unit));

  wb_rr_arbiter #(.NUM_UNITS(1), .DATA_WIDTH(DW), .ID_W(IW), .ROUND_ROBIN(1)) dut_one (
    .clk(clk), .rst(rst), .unit_valid(s_valid), .unit_id(s_id), .unit_data(s_data),
    .unit_ack(s_ack), .wb_suppress(s_sup), .wb_valid(s_wb_valid), .wb_id(s_wb_id),
    .wb_data(s_wb_data), .wb_unit(s_wb_unit));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending results per unit, last winner, last writeback payload.
  logic [N-1:0]  m_vld;
  logic [IW-1:0] m_id  [N];
  logic [DW-1:0] m_dat [N];
  logic          m_sup;
  int            m_ptr;
  int            last_unit;
  logic [IW-1:0] last_id;
  logic [DW-1:0] last_dat;

  // Winner = valid unit with the smallest circular distance after the last winner.
  function automatic int model_winner(input int p, input logic [N-1:0] v, input logic sup);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = N;
    if (sup) return -1;
    for (int i = 0; i < N; i++) begin
      d = (i - p - 1 + 2 * N) % N;
      if (v[i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_ptr     = N - 1;
    last_unit = 0;
    last_id   = '0;
    last_dat  = '0;
  endtask

  task automatic refill(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !m_vld[i]) begin
        m_vld[i] = 1'b1;
        m_id[i]  = IW'($urandom);
        m_dat[i] = $urandom;
      end
    end
  endtask

  task automatic drive();
    unit_valid  = m_vld;
    wb_suppress = m_sup;
    for (int i = 0; i < N; i++) begin
      unit_id[i*IW +: IW]   = m_id[i];
      unit_data[i*DW +: DW] = m_dat[i];
    end
  endtask

  // Called just after a rising edge: apply inputs, check ack mid-cycle,
  // then check the registered writeback just after the next edge.
  task automatic step(input string tag);
    int           w;
    logic [N-1:0] exp_ack;
    drive();
    w       = model_winner(m_ptr, m_vld, m_sup);
    exp_ack = (w >= 0) ? (N'(1) << w) : '0;
    @(negedge clk);
    check({tag, "_ack"}, 64'(unit_ack), 64'(exp_ack));
    @(posedge clk);
    #1;
    if (w >= 0) begin
      last_id   = m_id[w];
      last_dat  = m_dat[w];
      last_unit = w;
      m_ptr     = w;
      m_vld[w]  = 1'b0;
    end
    check({tag, "_wbv"},  64'(wb_valid), 64'(w >= 0));
    check({tag, "_wbid"}, 64'(wb_id),    64'(last_id));
    check({tag, "_wbd"},  64'(wb_data),  64'(last_dat));
    check({tag, "_wbu"},  64'(wb_unit),  64'(last_unit));
  endtask

  initial begin
    rst     = 1'b1;
    m_sup   = 1'b0;
    m_vld   = '0;
    refill(4'hF);
    drive();
    f_valid = '0; f_id = '0; f_data = '0; f_sup = 1'b0;
    s_valid = '0; s_id = '0; s_data = '0; s_sup = 1'b0;
    model_reset();

    // Reset state with every unit requesting: no acks, outputs cleared.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",   64'(unit_ack), 64'(0));
    check("rst_wbv",   64'(wb_valid), 64'(0));
    check("rst_wbid",  64'(wb_id),    64'(0));
    check("rst_wbd",   64'(wb_data),  64'(0));
    check("rst_wbu",   64'(wb_unit),  64'(0));
    check("rst_f_wbv", 64'(f_wb_valid), 64'(0));
    rst = 1'b0;

    // Saturation: grants 0,1,2,3,0,1,2,3 with wb_valid every cycle.
    for (int k = 0; k < 8; k++) begin
      step("sat");
      refill(4'hF);
    end
    // Drain without refilling, then one idle cycle (wb payload holds).
    for (int k = 0; k < 4; k++) step("drain");
    step("idle");

    // Single request: unit 2, id 5, data DEADBEEF.
    m_vld[2] = 1'b1; m_id[2] = 3'd5; m_dat[2] = 32'hDEADBEEF;
    step("single");
    check("single_id",   64'(wb_id),   64'(5));
    check("single_data", 64'(wb_data), 64'hDEADBEEF);
    check("single_unit", 64'(wb_unit), 64'(2));

    // Park the pointer on unit 1, then sparse wrap over units 1 and 3.
    refill(4'b0010);
    step("park");
    for (int k = 0; k < 4; k++) begin
      refill(4'b1010);
      step("sparse");
    end

    // Suppress with everybody valid for three cycles, then resume after the pointer.
    refill(4'hF);
    m_sup = 1'b1;
    for (int k = 0; k < 3; k++) step("sup");
    m_sup = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step("resume");
      refill(4'hF);
    end

    // Asynchronous reset mid-traffic: outputs clear before the next edge.
    drive();
    rst = 1'b1;
    #1;
    check("mrst_wbv",  64'(wb_valid), 64'(0));
    check("mrst_ack",  64'(unit_ack), 64'(0));
    check("mrst_wbid", 64'(wb_id),    64'(0));
    check("mrst_wbd",  64'(wb_data),  64'(0));
    check("mrst_wbu",  64'(wb_unit),  64'(0));
    @(posedge clk);
    #1;
    check("mrst_ack2", 64'(unit_ack), 64'(0));
    rst = 1'b0;
    model_reset();
    step("post_rst");

    // Randomized traffic with random suppress.
    for (int k = 0; k < 300; k++) begin
      m_sup = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++)
        if (!m_vld[i] && $urandom_range(0, 1) == 1) refill(N'(1) << i);
      step("rnd");
    end
    m_sup = 1'b0;

    // Fixed priority: units 0 and 2 valid, unit 0 wins until it drops.
    f_valid = 4'b0101;
    f_id[0 +: IW]    = 3'd1; f_data[0 +: DW]    = 32'h1111_0000;
    f_id[2*IW +: IW] = 3'd6; f_data[2*DW +: DW] = 32'h2222_0002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fp_ack0", 64'(f_ack), 64'(4'b0001));
      @(posedge clk);
      #1;
      check("fp_wbu0", 64'(f_wb_unit),  64'(0));
      check("fp_wbv0", 64'(f_wb_valid), 64'(1));
    end
    f_valid = 4'b0100;
    @(negedge clk);
    check("fp_ack2", 64'(f_ack), 64'(4'b0100));
    @(posedge clk);
    #1;
    check("fp_wbu2",  64'(f_wb_unit), 64'(2));
    check("fp_wbid2", 64'(f_wb_id),   64'(6));
    check("fp_wbd2",  64'(f_wb_data), 64'h2222_0002);
    f_valid = '0;

    // Single-unit arbiter: suppress blocks, then grant with wb_unit 0.
    s_valid = 1'b1; s_id = 3'd3; s_data = 32'hCAFE_0001; s_sup = 1'b1;
    @(negedge clk);
    check("one_sup_ack", 64'(s_ack), 64'(0));
    @(posedge clk);
    #1;
    check("one_sup_wbv", 64'(s_wb_valid), 64'(0));
    s_sup = 1'b0;
    @(negedge clk);
    check("one_ack", 64'(s_ack), 64'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("one_wbv",  64'(s_wb_valid), 64'(1));
    check("one_wbid", 64'(s_wb_id),    64'(3));
    check("one_wbd",  64'(s_wb_data),  64'hCAFE_0001);
    check("one_wbu",  64'(s_wb_unit),  64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
